seq_alu: RTL and testbench

Multi-cycle, parametrised successor of the team's 4-bit, 8-op combinational ALU.
- Same opcode map and parity output, generalised to WIDTH-bit operands and a 2*WIDTH-bit result.
- Modulo and multiply-rotate run iteratively instead of combinationally.
- Valid/ready handshake on both sides, so the block sits between an operand source and a result sink in the datapath.

---
 rtl/seq_alu_pkg.sv | 26 ++
 rtl/seq_alu_div.sv | 80 ++++++++
 rtl/seq_alu.sv | 201 ++++++++++++++++++++
 tb/tb_seq_alu.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu shared definitions: opcode map, FSM states
// and the shift-amount width helper.
package seq_alu_pkg;

  localparam logic [2:0] OP_NAND   = 3'b000;
  localparam logic [2:0] OP_NEG    = 3'b001;
  localparam logic [2:0] OP_OR2    = 3'b010;
  localparam logic [2:0] OP_XN     = 3'b011;
  localparam logic [2:0] OP_SHF    = 3'b100;
  localparam logic [2:0] OP_CAT    = 3'b101;
  localparam logic [2:0] OP_MOD    = 3'b110;
  localparam logic [2:0] OP_MULROT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_ROT,
    S_DIV,
    S_DONE
  } state_e;

  function automatic int shamt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_alu_div.sv
// Iterative restoring divider, one quotient bit per cycle.
// Only the remainder is kept; done pulses after N steps.
module seq_alu_div #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] rem_o
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(N);

  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  dvd_q, dvd_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  function automatic logic [N-1:0] step(
    input logic [N-1:0] r,
    input logic         bin,
    input logic [N-1:0] d
  );
    logic [N:0] t;
    logic [N:0] u;
    t = {r, bin};
    u = t - {1'b0, d};
    return (t >= {1'b0, d}) ? u[N-1:0] : t[N-1:0];
  endfunction

  assign done_o = busy_q && (cnt_q == LAST);
  assign busy_o = busy_q;
  assign rem_o  = rem_q;

  // The first step happens on the start edge itself
  always_comb begin
    rem_d  = rem_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      rem_d  = step('0, dividend_i[N-1], divisor_i);
      dvd_d  = dividend_i << 1;
      dvs_d  = divisor_i;
      cnt_d  = ONE;
      busy_d = 1'b1;
    end else if (done_o) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      rem_d = step(rem_q, dvd_q[N-1], dvs_q);
      dvd_d = dvd_q << 1;
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle WIDTH-bit ALU with valid/ready on both sides.
// Modulo and multiply-rotate iterate; other ops take one edge.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] alu,
  output logic               parity,
  output logic               err
);

  localparam int N  = 2 * WIDTH;
  localparam int S  = shamt_w(WIDTH);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] WLAST = CW'(WIDTH - 1);

  state_e state_q, state_d;

  logic [N-1:0]     mcand_q, mcand_d;
  logic [N-1:0]     prod_q, prod_d;
  logic [N-1:0]     alu_q, alu_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    rot_q, rot_d;
  logic             par_q, par_d;
  logic             err_q, err_d;

  logic         accept, load, by_zero;
  logic         mul_last, rot_last;
  logic         div_start, div_busy, div_done;
  logic [N-1:0] div_rem, za, zb;
  logic [N-1:0] simple_res, mac, rotl;

  assign za        = {{WIDTH{1'b0}}, a};
  assign zb        = {{WIDTH{1'b0}}, b};
  assign accept    = in_valid && in_ready;
  assign by_zero   = (b == '0);
  assign div_start = accept && (sel == OP_MOD) && !by_zero;
  assign mac       = prod_q + (mplr_q[0] ? mcand_q : '0);
  assign rotl      = {prod_q[N-2:0], prod_q[N-1]};
  assign mul_last  = (cnt_q == WLAST);
  assign rot_last  = ((cnt_q + ONE) == rot_q);

  seq_alu_div #(
    .N(N)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (div_start),
    .dividend_i({a, a}),
    .divisor_i (zb),
    .busy_o    (div_busy),
    .done_o    (div_done),
    .rem_o     (div_rem)
  );

  // Divide-by-zero falls through here and returns {a,a}
  always_comb begin
    simple_res = '0;
    unique case (sel)
      OP_NAND: simple_res = {{WIDTH{1'b0}}, ~(a & b)};
      OP_NEG:  simple_res = '0 - zb;
      OP_OR2:  simple_res = {a | b, a | b};
      OP_XN:   simple_res = {a ^ b, ~(a | b)};
      OP_SHF:  simple_res = (a >= b) ? (za << b[S-1:0])
                                     : (zb << a[S-1:0]);
      OP_CAT:  simple_res = {a, b};
      OP_MOD:  simple_res = {a, a};
      default: simple_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (sel == OP_MULROT) state_d = S_MUL;
          else if (div_start)   state_d = S_DIV;
          else                  state_d = S_DONE;
        end
      end
      S_MUL: begin
        if (mul_last)
          state_d = (rot_q == '0) ? S_DONE : S_ROT;
      end
      S_ROT:   if (rot_last)  state_d = S_DONE;
      S_DIV:   if (div_done)  state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) && !div_busy;
    out_valid = (state_q == S_DONE);
  end

  always_comb begin
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    rot_d   = rot_q;
    alu_d   = alu_q;
    err_d   = err_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          mcand_d = za;
          mplr_d  = b;
          prod_d  = '0;
          cnt_d   = '0;
          rot_d   = CW'(int'(b) % N);
          if (sel != OP_MULROT && !div_start) begin
            alu_d = simple_res;
            err_d = (sel == OP_MOD);
            load  = 1'b1;
          end
        end
      end
      S_MUL: begin
        prod_d  = mac;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + ONE;
        if (mul_last) begin
          cnt_d = '0;
          if (rot_q == '0) begin
            alu_d = mac;
            err_d = 1'b0;
            load  = 1'b1;
          end
        end
      end
      S_ROT: begin
        prod_d = rotl;
        cnt_d  = cnt_q + ONE;
        if (rot_last) begin
          alu_d = rotl;
          err_d = 1'b0;
          load  = 1'b1;
        end
      end
      S_DIV: begin
        if (div_done) begin
          alu_d = div_rem;
          err_d = 1'b0;
          load  = 1'b1;
        end
      end
      default: ;
    endcase
    par_d = load ? ((^alu_d) ^ ODD_PARITY) : par_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      rot_q   <= '0;
      alu_q   <= '0;
      err_q   <= 1'b0;
      par_q   <= ODD_PARITY;
    end else begin
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      rot_q   <= rot_d;
      alu_q   <= alu_d;
      err_q   <= err_d;
      par_q   <= par_d;
    end
  end

  assign alu    = alu_q;
  assign parity = par_q;
  assign err    = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: fixed vectors, handshake/reset
// sequences and random ops against an arithmetic model.
module tb_seq_alu;

  localparam int W   = 4;
  localparam bit ODD = 1'b0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   sel = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [2*W-1:0] alu;
  logic         parity;
  logic         err;

  int checks = 0;
  int failures = 0;

  seq_alu #(
    .WIDTH(W),
    .ODD_PARITY(ODD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sel      (sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu      (alu),
    .parity   (parity),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] s;
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] ealu;
    logic       epar;
    logic       eerr;
    int         elat;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Reference: opcode rules as plain integer arithmetic
  task automatic model(input int s, input int x,
                       input int y, output int res,
                       output int er, output int lt);
    int p;
    int r;
    er = 0;
    lt = 1;
    p  = 0;
    r  = 0;
    case (s)
      0: res = (~(x & y)) & 15;
      1: res = (256 - y) % 256;
      2: res = (x | y) * 16 + (x | y);
      3: res = (x ^ y) * 16 + ((~(x | y)) & 15);
      4: res = (x >= y) ? (x << (y % 4)) : (y << (x % 4));
      5: res = x * 16 + y;
      6: begin
        if (y == 0) begin
          res = x * 17;
          er  = 1;
        end else begin
          res = (x * 17) % y;
          lt  = 2 * W + 1;
        end
      end
      default: begin
        p   = x * y;
        r   = y % 8;
        res = ((p << r) | (p >> (8 - r))) & 255;
        lt  = 1 + W + r;
      end
    endcase
  endtask

  task automatic issue(input logic [2:0] s,
                       input logic [3:0] x,
                       input logic [3:0] y,
                       output logic [7:0] ra,
                       output logic rp, output logic re,
                       output int lat);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    sel = s;
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 4'($urandom);
    b = 4'($urandom);
    sel = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
    ra = alu;
    rp = parity;
    re = err;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
    chk("valid_drop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0] ra;
    logic rp;
    logic re;
    int lat;
    int mres;
    int merr;
    int mlat;
    int mpar;

    tbl[0]  = '{3'b110, 4'd5,  4'd3, 8'h01, 1'b1, 1'b0, 9};
    tbl[1]  = '{3'b111, 4'd3,  4'd5, 8'hE1, 1'b0, 1'b0, 10};
    tbl[2]  = '{3'b111, 4'd3,  4'd8, 8'h18, 1'b0, 1'b0, 5};
    tbl[3]  = '{3'b001, 4'd0,  4'd3, 8'hFD, 1'b1, 1'b0, 1};
    tbl[4]  = '{3'b001, 4'd7,  4'd0, 8'h00, 1'b0, 1'b0, 1};
    tbl[5]  = '{3'b100, 4'd6,  4'd3, 8'h30, 1'b0, 1'b0, 1};
    tbl[6]  = '{3'b100, 4'd2,  4'd9, 8'h24, 1'b0, 1'b0, 1};
    tbl[7]  = '{3'b100, 4'd0,  4'd0, 8'h00, 1'b0, 1'b0, 1};
    tbl[8]  = '{3'b110, 4'd5,  4'd0, 8'h55, 1'b0, 1'b1, 1};
    tbl[9]  = '{3'b101, 4'hA,  4'h5, 8'hA5, 1'b0, 1'b0, 1};
    tbl[10] = '{3'b000, 4'hC,  4'hA, 8'h07, 1'b1, 1'b0, 1};
    tbl[11] = '{3'b010, 4'd1,  4'd2, 8'h33, 1'b0, 1'b0, 1};
    tbl[12] = '{3'b011, 4'd5,  4'd3, 8'h68, 1'b1, 1'b0, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu", 32'(alu), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_parity", 32'(parity), 32'(ODD));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      issue(tbl[i].s, tbl[i].x, tbl[i].y, ra, rp, re, lat);
      chk($sformatf("vec%0d_alu", i), 32'(ra), 32'(tbl[i].ealu));
      chk($sformatf("vec%0d_par", i), 32'(rp), 32'(tbl[i].epar));
      chk($sformatf("vec%0d_err", i), 32'(re), 32'(tbl[i].eerr));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].elat));
      settle();
    end

    // Stall in DONE while junk requests arrive
    out_ready = 1'b0;
    issue(3'b011, 4'd5, 4'd3, ra, rp, re, lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      sel = 3'($urandom);
      a = 4'($urandom);
      b = 4'($urandom);
      @(posedge clk);
      #1;
      chk("hold_alu", 32'(alu), 32'h68);
      chk("hold_par", 32'(parity), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release", 32'(out_valid), 32'd0);
    chk("hold_idle_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("no_queued_op", 32'(out_valid), 32'd0);
    end

    // Reset in the middle of a division
    @(negedge clk);
    sel = 3'b110;
    a = 4'd7;
    b = 4'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_alu", 32'(alu), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_parity", 32'(parity), 32'(ODD));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      chk("abort_no_result", 32'(out_valid), 32'd0);
    end
    issue(3'b110, 4'd9, 4'd5, ra, rp, re, lat);
    chk("post_rst_alu", 32'(ra), 32'h03);
    chk("post_rst_par", 32'(rp), 32'd0);
    chk("post_rst_lat", 32'(lat), 32'd9);
    settle();

    for (int i = 0; i < 150; i++) begin
      logic [2:0] s;
      logic [3:0] x;
      logic [3:0] y;
      s = 3'($urandom);
      x = 4'($urandom);
      y = 4'($urandom);
      if ($urandom_range(0, 7) == 0) y = '0;
      model(int'(s), int'(x), int'(y), mres, merr, mlat);
      mpar = ($countones(mres) % 2) ^ int'(ODD);
      issue(s, x, y, ra, rp, re, lat);
      chk($sformatf("rnd_alu s=%0d a=%0d b=%0d", s, x, y),
          32'(ra), 32'(mres));
      chk("rnd_par", 32'(rp), 32'(mpar));
      chk("rnd_err", 32'(re), 32'(merr));
      chk("rnd_lat", 32'(lat), 32'(mlat));
      settle();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
